// File: rtl/switch_port_in.sv
// Front-panel switch input port: synchronises and debounces 8 active-low switches and
// presents them, plus per-bit change flags, to the CPU through a snapshot-on-read port.
module switch_port_in #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned DEB_COUNT = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] sw_n,
    input  logic       data_sel,
    input  logic       stat_sel,
    input  logic       io_rd,
    output logic [7:0] portDI,
    output logic       change_any,
    output logic [7:0] sw_state
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntW = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_COUNT - 1);

    // Synchroniser, debounce and read-handshake state
    logic [7:0]      sync1_q, sync2_q;
    logic [7:0]      sw_closed;
    logic [PreW-1:0] pre_q, pre_d;
    logic            tick;
    logic [CntW-1:0] cnt_q [8];
    logic [CntW-1:0] cnt_d [8];
    logic [7:0]      toggle;
    logic [7:0]      sw_state_q, sw_state_d;
    logic [7:0]      pend_q, pend_d;
    logic [7:0]      snap_q, snap_d;
    logic [7:0]      clr_q, clr_d;
    logic            rd_q;
    logic            rd_start, rd_end;
    logic            act_q, act_d;
    logic            is_data_q, is_data_d;
    logic            sel_ok;
    logic [7:0]      port_q, port_d;

    assign sw_closed = ~sync2_q;
    assign tick      = (pre_q == PreMax);
    assign pre_d     = tick ? '0 : pre_q + PreW'(1);

    always_comb begin
        toggle = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sw_closed[i] == sw_state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    cnt_d[i]  = '0;
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign sw_state_d = sw_state_q ^ toggle;

    assign rd_start = io_rd & ~rd_q;
    assign rd_end   = ~io_rd & rd_q;
    assign sel_ok   = is_data_q ? data_sel : stat_sel;

    always_comb begin
        pend_d    = pend_q;
        snap_d    = snap_q;
        clr_d     = clr_q;
        act_d     = act_q;
        is_data_d = is_data_q;
        if (rd_end) begin
            pend_d = pend_q & ~clr_q;
            clr_d  = '0;
            act_d  = 1'b0;
        end
        // A toggle on the clearing edge must survive the acknowledge
        pend_d = pend_d | toggle;
        if (rd_start) begin
            if (data_sel) begin
                snap_d    = sw_state_q;
                clr_d     = pend_q;
                act_d     = 1'b1;
                is_data_d = 1'b1;
            end else if (stat_sel) begin
                snap_d    = pend_q;
                clr_d     = '0;
                act_d     = 1'b1;
                is_data_d = 1'b0;
            end else begin
                act_d = 1'b0;
            end
        end
    end

    assign port_d = (io_rd && act_q && sel_ok) ? snap_q : 8'hFF;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 8'hFF;
            sync2_q    <= 8'hFF;
            pre_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
            sw_state_q <= 8'h00;
            pend_q     <= 8'h00;
            snap_q     <= 8'h00;
            clr_q      <= 8'h00;
            rd_q       <= 1'b0;
            act_q      <= 1'b0;
            is_data_q  <= 1'b0;
            port_q     <= 8'hFF;
        end else begin
            sync1_q    <= sw_n;
            sync2_q    <= sync1_q;
            pre_q      <= pre_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sw_state_q <= sw_state_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            clr_q      <= clr_d;
            rd_q       <= io_rd;
            act_q      <= act_d;
            is_data_q  <= is_data_d;
            port_q     <= port_d;
        end
    end

    assign portDI     = port_q;
    assign change_any = |pend_q;
    assign sw_state   = sw_state_q;

endmodule

// File: tb/tb_switch_port_in.sv
// Bench for switch_port_in: directed vector table for the timing corners, then random
// switch/read traffic checked every clock against a behavioural model.
module tb_switch_port_in;

    localparam int unsigned TDIV = 4;
    localparam int unsigned DEB  = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] sw_n = 8'h00;
    logic       data_sel = 1'b0;
    logic       stat_sel = 1'b0;
    logic       io_rd = 1'b0;
    logic [7:0] portDI;
    logic       change_any;
    logic [7:0] sw_state;

    int n_checks = 0;
    int n_pass   = 0;

    switch_port_in #(
        .TICK_DIV (TDIV),
        .DEB_COUNT(DEB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sw_n      (sw_n),
        .data_sel  (data_sel),
        .stat_sel  (stat_sel),
        .io_rd     (io_rd),
        .portDI    (portDI),
        .change_any(change_any),
        .sw_state  (sw_state)
    );

    always #5 clock = ~clock;

    // Behavioural model: pins reach the debouncer two clocks late; every TDIV-th clock is a
    // sample; a bit flips after DEB consecutive disagreeing samples.
    logic [7:0] m_state, m_pend, m_snap, m_clr, m_port;
    logic [7:0] m_pins[$];
    int         m_run[8];
    int         m_clk;
    logic       m_io_prev, m_act, m_is_data;

    function automatic void model_reset();
        m_state = 8'h00; m_pend = 8'h00; m_snap = 8'h00; m_clr = 8'h00; m_port = 8'hFF;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_clk = 0; m_io_prev = 1'b0; m_act = 1'b0; m_is_data = 1'b0;
        m_pins = '{8'hFF, 8'hFF};
    endfunction

    function automatic void model_step();
        logic [7:0] closed, flips, npend, nport;
        bit         sample;
        closed = ~m_pins[0];
        void'(m_pins.pop_front());
        m_pins.push_back(sw_n);
        sample = ((m_clk % TDIV) == TDIV - 1);
        m_clk++;
        flips = 8'h00;
        if (sample) begin
            for (int i = 0; i < 8; i++) begin
                if (closed[i] == m_state[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        flips[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
        end
        nport = (io_rd && m_act && (m_is_data ? data_sel : stat_sel)) ? m_snap : 8'hFF;
        npend = m_pend;
        if (!io_rd && m_io_prev) npend = npend & ~m_clr;
        npend = npend | flips;
        if (io_rd && !m_io_prev) begin
            if (data_sel) begin
                m_snap = m_state; m_clr = m_pend; m_act = 1'b1; m_is_data = 1'b1;
            end else if (stat_sel) begin
                m_snap = m_pend; m_clr = 8'h00; m_act = 1'b1; m_is_data = 1'b0;
            end else m_act = 1'b0;
        end else if (!io_rd && m_io_prev) begin
            m_clr = 8'h00; m_act = 1'b0;
        end
        m_state   = m_state ^ flips;
        m_pend    = npend;
        m_port    = nport;
        m_io_prev = io_rd;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step();
        @(negedge clock);
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] sw;
        bit         ds, ss, rd;
        int         n;
        logic [7:0] st, port;
        bit         any;
    } vec_t;

    vec_t vec[31];

    function automatic vec_t mk(bit rst, logic [7:0] sw, bit ds, bit ss, bit rd, int n,
                                logic [7:0] st, logic [7:0] port, bit any);
        vec_t v;
        v.rst = rst; v.sw = sw; v.ds = ds; v.ss = ss; v.rd = rd; v.n = n;
        v.st = st; v.port = port; v.any = any;
        return v;
    endfunction

    task automatic run_vec(input int k);
        reset_n  = !vec[k].rst;
        sw_n     = vec[k].sw;
        data_sel = vec[k].ds;
        stat_sel = vec[k].ss;
        io_rd    = vec[k].rd;
        repeat (vec[k].n) cyc();
        chk($sformatf("vec%0d sw_state", k), sw_state, vec[k].st);
        chk($sformatf("vec%0d portDI", k), portDI, vec[k].port);
        chk($sformatf("vec%0d change_any", k), {7'b0, change_any}, {7'b0, vec[k].any});
    endtask

    task automatic rnd_check();
        cyc();
        chk("rnd sw_state", sw_state, m_state);
        chk("rnd portDI", portDI, m_port);
        chk("rnd change_any", {7'b0, change_any}, {7'b0, |m_pend});
    endtask

    task automatic rnd_pins();
        if ($urandom_range(0, 19) == 0) sw_n[$urandom_range(0, 7)] ^= 1'b1;
    endtask

    initial begin
        // reset, power-up with all switches closed
        vec[0]  = mk(1, 8'h00, 0, 0, 0, 2, 8'h00, 8'hFF, 0);
        vec[1]  = mk(0, 8'h00, 0, 0, 0, 11, 8'h00, 8'hFF, 0);
        vec[2]  = mk(0, 8'h00, 0, 0, 0, 1, 8'hFF, 8'hFF, 1);
        // glitch of 2 samples, then a real press of 3 samples
        vec[3]  = mk(1, 8'hFF, 0, 0, 0, 2, 8'h00, 8'hFF, 0);
        vec[4]  = mk(0, 8'hFE, 0, 0, 0, 7, 8'h00, 8'hFF, 0);
        vec[5]  = mk(0, 8'hFF, 0, 0, 0, 5, 8'h00, 8'hFF, 0);
        vec[6]  = mk(0, 8'hFE, 0, 0, 0, 11, 8'h00, 8'hFF, 0);
        vec[7]  = mk(0, 8'hFE, 0, 0, 0, 1, 8'h01, 8'hFF, 1);
        // data read, 10 clocks, acknowledges pending
        vec[8]  = mk(0, 8'hFE, 1, 0, 1, 1, 8'h01, 8'hFF, 1);
        vec[9]  = mk(0, 8'hFE, 1, 0, 1, 1, 8'h01, 8'h01, 1);
        vec[10] = mk(0, 8'hFE, 1, 0, 1, 8, 8'h01, 8'h01, 1);
        vec[11] = mk(0, 8'hFE, 0, 0, 0, 1, 8'h01, 8'hFF, 0);
        // bits 0 and 2 flip together -> pending 05; status read does not clear
        vec[12] = mk(0, 8'hFB, 0, 0, 0, 12, 8'h01, 8'hFF, 0);
        vec[13] = mk(0, 8'hFB, 0, 0, 0, 1, 8'h04, 8'hFF, 1);
        vec[14] = mk(0, 8'hFB, 0, 1, 1, 1, 8'h04, 8'hFF, 1);
        vec[15] = mk(0, 8'hFB, 0, 1, 1, 4, 8'h04, 8'h05, 1);
        vec[16] = mk(0, 8'hFB, 0, 0, 0, 1, 8'h04, 8'hFF, 1);
        vec[17] = mk(0, 8'hFB, 1, 0, 1, 2, 8'h04, 8'h04, 1);
        vec[18] = mk(0, 8'hFB, 0, 0, 0, 1, 8'h04, 8'hFF, 0);
        // pending 01, then bit1 changes during a data read
        vec[19] = mk(0, 8'hFA, 0, 0, 0, 10, 8'h04, 8'hFF, 0);
        vec[20] = mk(0, 8'hFA, 0, 0, 0, 1, 8'h05, 8'hFF, 1);
        vec[21] = mk(0, 8'hF8, 1, 0, 1, 11, 8'h05, 8'h05, 1);
        vec[22] = mk(0, 8'hF8, 1, 0, 1, 1, 8'h07, 8'h05, 1);
        vec[23] = mk(0, 8'hF8, 1, 0, 1, 4, 8'h07, 8'h05, 1);
        vec[24] = mk(0, 8'hF8, 0, 0, 0, 1, 8'h07, 8'hFF, 1);
        vec[25] = mk(0, 8'hF8, 0, 1, 1, 2, 8'h07, 8'h02, 1);
        vec[26] = mk(0, 8'hF8, 0, 0, 0, 1, 8'h07, 8'hFF, 1);
        // after the mid-read reset
        vec[27] = mk(1, 8'hFE, 1, 0, 1, 2, 8'h00, 8'hFF, 0);
        vec[28] = mk(0, 8'hFE, 0, 0, 0, 11, 8'h00, 8'hFF, 0);
        vec[29] = mk(0, 8'hFE, 0, 0, 0, 1, 8'h01, 8'hFF, 1);

        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("reset sw_state", sw_state, 8'h00);
        chk("reset portDI", portDI, 8'hFF);
        chk("reset change_any", {7'b0, change_any}, 8'h00);
        @(negedge clock);

        for (int k = 0; k < 27; k++) run_vec(k);

        // reset asserted in the middle of a data read
        sw_n = 8'hF8; data_sel = 1'b1; io_rd = 1'b1;
        cyc();
        cyc();
        chk("midread portDI", portDI, 8'h07);
        sw_n = 8'hFE;
        reset_n = 1'b0;
        #1;
        chk("midreset portDI", portDI, 8'hFF);
        chk("midreset change_any", {7'b0, change_any}, 8'h00);
        chk("midreset sw_state", sw_state, 8'h00);
        @(negedge clock);
        for (int k = 27; k < 30; k++) run_vec(k);

        // random traffic against the model
        reset_n = 1'b0; io_rd = 1'b0; data_sel = 1'b0; stat_sel = 1'b0;
        sw_n = 8'($urandom);
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int t = 0; t < 400; t++) begin
            int idle, len, sel, drop;
            idle = $urandom_range(1, 8);
            len  = $urandom_range(2, 12);
            sel  = $urandom_range(0, 3);
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : len + 1;
            if (t == 200) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                chk("rnd reset portDI", portDI, 8'hFF);
                @(negedge clock);
                cyc();
                reset_n = 1'b1;
            end
            for (int c = 0; c < idle; c++) begin
                rnd_pins();
                io_rd = 1'b0; data_sel = 1'b0; stat_sel = 1'b0;
                rnd_check();
            end
            for (int c = 0; c < len; c++) begin
                rnd_pins();
                io_rd    = 1'b1;
                data_sel = sel[0] && (c < drop);
                stat_sel = sel[1] && (c < drop);
                rnd_check();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
